// File: rtl/uart_frame_loader_if.sv
// Bundle between the frame loader and its neighbours: the Avalon-MM path to the UART
// registers, the packed-pixel stream, and the frame status outputs.
interface uart_frame_loader_if #(
    parameter int PACK_BYTES = 3
);
    logic [4:0]              avm_address;
    logic                    avm_read;
    logic [31:0]             avm_readdata;
    logic                    avm_write;
    logic [31:0]             avm_writedata;
    logic                    avm_waitrequest;
    logic [8*PACK_BYTES-1:0] pix_data;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    pix_last;
    logic                    frame_done;
    logic [15:0]             frame_count;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest,
        output pix_data, pix_valid, pix_last, frame_done, frame_count,
        input  pix_ready
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest,
        input  pix_data, pix_valid, pix_last, frame_done, frame_count,
        output pix_ready
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Polls a UART over Avalon-MM, packs received bytes MSB-first into pixel words, counts
// fixed-size frames and optionally writes an acknowledge byte after each frame.
module uart_frame_loader #(
    parameter int         FRAME_BYTES = 12288,
    parameter int         PACK_BYTES  = 3,
    parameter int         ACK_EN      = 1,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter int         RX_BASE     = 0,
    parameter int         TX_BASE     = 4,
    parameter int         STATUS_BASE = 8,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    uart_frame_loader_if.master bus
);
    localparam int PIXELS = FRAME_BYTES / PACK_BYTES;
    localparam int IDX_W  = (PACK_BYTES > 1) ? $clog2(PACK_BYTES) : 1;
    localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int PIX_W  = 8 * PACK_BYTES;

    typedef enum logic [2:0] {
        S_POLL_RX,
        S_READ_RX,
        S_OUT,
        S_POLL_TX,
        S_WRITE_TX
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   byte_idx, byte_idx_n;
    logic [CNT_W-1:0]   pix_cnt, pix_cnt_n;
    logic [4:0]         address, address_n;
    logic               rd_req, rd_req_n;
    logic               wr_req, wr_req_n;
    logic [31:0]        wdata, wdata_n;
    logic [PIX_W-1:0]   pixel, pixel_n;
    logic               valid, valid_n;
    logic               last, last_n;
    logic               done, done_n;
    logic [15:0]        count, count_n;
    logic               rd_done, wr_done;

    // NOTE: every output is a register; the next-state block computes their next values.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state    <= S_POLL_RX;
            byte_idx <= '0;
            pix_cnt  <= '0;
            address  <= 5'(STATUS_BASE);
            rd_req   <= 1'b0;
            wr_req   <= 1'b0;
            wdata    <= '0;
            pixel    <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_n;
            byte_idx <= byte_idx_n;
            pix_cnt  <= pix_cnt_n;
            address  <= address_n;
            rd_req   <= rd_req_n;
            wr_req   <= wr_req_n;
            wdata    <= wdata_n;
            pixel    <= pixel_n;
            valid    <= valid_n;
            last     <= last_n;
            done     <= done_n;
            count    <= count_n;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments up front keep this block free of latches.
        state_n    = state;
        byte_idx_n = byte_idx;
        pix_cnt_n  = pix_cnt;
        address_n  = address;
        rd_req_n   = rd_req;
        wr_req_n   = wr_req;
        wdata_n    = wdata;
        pixel_n    = pixel;
        valid_n    = valid;
        last_n     = last;
        done_n     = 1'b0;
        count_n    = count;
        rd_done    = rd_req && !bus.avm_waitrequest;
        wr_done    = wr_req && !bus.avm_waitrequest;

        case (state)
            S_POLL_RX: begin
                rd_req_n  = 1'b1;
                address_n = 5'(STATUS_BASE);
                if (rd_done && bus.avm_readdata[RX_OK_BIT]) begin
                    state_n   = S_READ_RX;
                    address_n = 5'(RX_BASE);
                end
            end
            S_READ_RX: begin
                if (rd_done) begin
                    for (int i = 0; i < PACK_BYTES; i++) begin
                        if (byte_idx == IDX_W'(i))
                            pixel_n[8*(PACK_BYTES-1-i) +: 8] = bus.avm_readdata[7:0];
                    end
                    if (byte_idx == IDX_W'(PACK_BYTES - 1)) begin
                        byte_idx_n = '0;
                        rd_req_n   = 1'b0;
                        valid_n    = 1'b1;
                        last_n     = (pix_cnt == CNT_W'(PIXELS - 1));
                        state_n    = S_OUT;
                    end else begin
                        byte_idx_n = byte_idx + IDX_W'(1);
                        address_n  = 5'(STATUS_BASE);
                        state_n    = S_POLL_RX;
                    end
                end
            end
            S_OUT: begin
                if (bus.pix_ready) begin
                    valid_n   = 1'b0;
                    last_n    = 1'b0;
                    rd_req_n  = 1'b1;
                    address_n = 5'(STATUS_BASE);
                    if (pix_cnt == CNT_W'(PIXELS - 1)) begin
                        pix_cnt_n = '0;
                        done_n    = 1'b1;
                        count_n   = count + 16'd1;
                        state_n   = (ACK_EN != 0) ? S_POLL_TX : S_POLL_RX;
                    end else begin
                        pix_cnt_n = pix_cnt + CNT_W'(1);
                        state_n   = S_POLL_RX;
                    end
                end
            end
            S_POLL_TX: begin
                rd_req_n  = 1'b1;
                address_n = 5'(STATUS_BASE);
                if (rd_done && bus.avm_readdata[TX_OK_BIT]) begin
                    rd_req_n  = 1'b0;
                    wr_req_n  = 1'b1;
                    address_n = 5'(TX_BASE);
                    wdata_n   = {24'h0, ACK_BYTE};
                    state_n   = S_WRITE_TX;
                end
            end
            S_WRITE_TX: begin
                if (wr_done) begin
                    wr_req_n  = 1'b0;
                    rd_req_n  = 1'b1;
                    address_n = 5'(STATUS_BASE);
                    state_n   = S_POLL_RX;
                end
            end
            default: state_n = S_POLL_RX;
        endcase
    end

    assign bus.avm_address   = address;
    assign bus.avm_read      = rd_req;
    assign bus.avm_write     = wr_req;
    assign bus.avm_writedata = wdata;
    assign bus.pix_data      = pixel;
    assign bus.pix_valid     = valid;
    assign bus.pix_last      = last;
    assign bus.frame_done    = done;
    assign bus.frame_count   = count;
endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Parametrised frame receiver that polls an Avalon-MM RS-232 UART core and packs the incoming byte stream into fixed-width pixel words on a ready/valid stream. It counts fixed-size frames, flags the last pixel of each frame, and can optionally write an acknowledge byte back through the UART TX register after every frame. It sits between the UART IP and the frame buffer / image processing pipeline, and it adds output backpressure that the current single-byte loader does not have.

## Interface
- FRAME_BYTES, 12288, bytes per frame; must be a multiple of PACK_BYTES.
- PACK_BYTES, 3, bytes packed per output word (1..4).
- ACK_EN, 1, when 1, write ACK_BYTE to the TX register after each frame.
- ACK_BYTE, 8'h06, acknowledge byte value.
- RX_BASE / TX_BASE / STATUS_BASE, 0 / 4 / 8, UART register byte addresses.
- RX_OK_BIT / TX_OK_BIT, 7 / 6, status register ready bits.
- avm_clk  in  1  single clock; all state updates on its rising edge.
- avm_rst  in  1  asynchronous, active-high reset.
- avm_address  out  5  Avalon address.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  32  Avalon read data.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  Avalon write data.
- avm_waitrequest  in  1  Avalon stall.
- pix_data  out  8*PACK_BYTES  packed pixel; the first received byte is in the MSBs.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts.
- pix_last  out  1  qualifies the last pixel of a frame.
- frame_done  out  1  one-cycle pulse when the last pixel is accepted.
- frame_count  out  16  completed frames; wraps at 65535 -> 0.

## Operation
- Derived values: PIXELS = FRAME_BYTES/PACK_BYTES. Byte index width = $clog2(PACK_BYTES). Pixel counter width = $clog2(PIXELS).
- Avalon transfer rule: a transfer completes in any cycle where request=1 and avm_waitrequest=0. Address, request and writedata stay stable until completion. readdata is sampled in the completing cycle.
- All Avalon and stream outputs are registered.
- States:
  - S_POLL_RX: read=1, address=STATUS_BASE.
    - On completion with readdata[RX_OK_BIT]=1, go to S_READ_RX.
    - Otherwise stay; read remains high, which is a back-to-back poll.
  - S_READ_RX: read=1, address=RX_BASE.
    - On completion, write readdata[7:0] into byte slot byte_idx. Slot 0 is bits [8*PACK_BYTES-1 -: 8].
    - If byte_idx==PACK_BYTES-1: clear byte_idx, deassert read and go to S_OUT.
    - Otherwise increment byte_idx and go to S_POLL_RX.
  - S_OUT: pix_valid=1. pix_data is stable. pix_last = (pix_cnt==PIXELS-1).
    - On pix_ready=1: drop pix_valid.
    - If not last: increment pix_cnt and go to S_POLL_RX.
    - If last: clear pix_cnt, pulse frame_done, increment frame_count, then go to S_POLL_TX when ACK_EN=1, else to S_POLL_RX.
  - S_POLL_TX: read=1, address=STATUS_BASE.
    - On completion with readdata[TX_OK_BIT]=1, deassert read and go to S_WRITE_TX.
  - S_WRITE_TX: write=1, address=TX_BASE, writedata={24'h0, ACK_BYTE}.
    - On completion, write=0 and go to S_POLL_RX.
- read and write are never asserted together.
- Reset mid-frame: the partial pixel and pix_cnt are discarded. The next byte received after reset is slot 0 of pixel 0.

## Timing
- Reset values:
  - avm_read=0, avm_write=0, avm_address=STATUS_BASE, avm_writedata=0.
  - pix_valid=0, pix_data=0, pix_last=0, frame_done=0, frame_count=0.
  - Internal state: S_POLL_RX, byte_idx=0, pix_cnt=0.
- avm_read rises on the first rising edge after avm_rst deasserts.
- With zero waitrequest, each byte takes 2 cycles (status read, then data read).
- pix_valid rises on the edge after the final byte's read completion. It holds until the pix_ready handshake cycle and is 0 in the following cycle.
- While pix_valid is high there is no Avalon activity, so backpressure stalls UART reads. The UART FIFO absorbs the overflow.
- frame_done is high for exactly the cycle after the last-pixel handshake. frame_count updates on the same edge.
- pix_ready held high: minimum pixel period = 2*PACK_BYTES+1 cycles.

## Test plan
- Reset, then RX_OK=0 for 10 polls -> avm_read stays 1 at address 8, no RX read, pix_valid=0.
- FRAME_BYTES=6, PACK_BYTES=3; bytes 11,22,33,44,55,66 with zero wait -> pix_data=0x112233 with pix_last=0, then 0x445566 with pix_last=1, frame_done pulses once, frame_count=1.
- Same frame with pix_ready low for 20 cycles on pixel 0 -> pix_valid and pix_data held, no Avalon requests, then normal completion.
- ACK_EN=1, TX_OK low for 5 polls then high -> exactly one write at address 4 with data 0x06, then RX polling resumes.
- waitrequest=1 for 3 cycles on each transfer -> address and read held stable, correct bytes captured, no double counting.
- avm_rst pulsed after 2 bytes of a frame -> all outputs return to reset values; the next 6 bytes form a complete frame with frame_count=1.
